// File: rtl/half_adder_if.sv
// Bundles the half adder's data, control and result signals so they travel as one port.
// Parameter: CNT_W - width of the op/carry event counters carried on the bus.
// master drives a/b/in_valid/clr and observes results; slave is the adder side.
interface half_adder_if #(
    parameter int CNT_W = 8
);
    logic             a;          // addend bit A
    logic             b;          // addend bit B
    logic             in_valid;   // qualifies a/b for the registered path
    logic             clr;        // synchronous clear of both counters
    logic             s;          // combinational sum
    logic             c;          // combinational carry
    logic             s_q;        // registered sum
    logic             c_q;        // registered carry
    logic             out_valid;  // s_q/c_q hold a fresh result this cycle
    logic [CNT_W-1:0] carry_cnt;  // accepted inputs that produced a carry
    logic [CNT_W-1:0] op_cnt;     // accepted inputs

    modport master (
        output a, b, in_valid, clr,
        input  s, c, s_q, c_q, out_valid, carry_cnt, op_cnt
    );

    modport slave (
        input  a, b, in_valid, clr,
        output s, c, s_q, c_q, out_valid, carry_cnt, op_cnt
    );
endinterface

// File: rtl/half_adder.sv
// Half adder with a live combinational result plus a registered, valid-qualified copy and event counters.
// Latency: s/c zero cycles; s_q/c_q/out_valid/counters one cycle after an accepted input.
// No backpressure: every in_valid cycle is accepted; counters saturate instead of wrapping.
// Ports: clk (rising edge), rst_n (async assert, active low), bus (half_adder_if slave):
//   inputs a, b, in_valid, clr; outputs s, c, s_q, c_q, out_valid, carry_cnt, op_cnt.
module half_adder #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    half_adder_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_sum;
    logic             w_carry;
    logic             r_s_q;
    logic             r_c_q;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_op_cnt;
    logic [CNT_W-1:0] r_carry_cnt;

    // Combinational path depends only on a/b so it stays live through reset and with no clock.
    assign w_sum   = bus.a ^ bus.b;
    assign w_carry = bus.a & bus.b;

    assign bus.s         = w_sum;
    assign bus.c         = w_carry;
    assign bus.s_q       = r_s_q;
    assign bus.c_q       = r_c_q;
    assign bus.out_valid = r_out_valid;
    assign bus.op_cnt    = r_op_cnt;
    assign bus.carry_cnt = r_carry_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q       <= 1'b0;
            r_c_q       <= 1'b0;
            r_out_valid <= 1'b0;
            r_op_cnt    <= '0;
            r_carry_cnt <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s_q <= w_sum;
                r_c_q <= w_carry;
            end
            // clr wins over a coincident increment; the result registers above are not affected by it.
            if (bus.clr) begin
                r_op_cnt    <= '0;
                r_carry_cnt <= '0;
            end else if (bus.in_valid) begin
                if (r_op_cnt != CNT_MAX) begin
                    r_op_cnt <= r_op_cnt + 1'b1;
                end
                // Saturates independently, so it can keep climbing after op_cnt is pinned.
                if (w_carry && (r_carry_cnt != CNT_MAX)) begin
                    r_carry_cnt <= r_carry_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: scoreboard queue fed by stimulus, drained by an out_valid monitor.
// Latency: checks results one cycle after acceptance, sampled on the falling edge.
// No backpressure to model; directed vectors with hand-computed expectations.
module tb_half_adder;
    typedef struct packed {
        logic       s_q;
        logic       c_q;
        logic [7:0] op;
        logic [7:0] carry;
    } exp_t;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;

    int errors = 0;
    int checks = 0;
    int m_op = 0;
    int m_carry = 0;
    exp_t q[$];

    half_adder_if #(.CNT_W(8)) bus ();
    half_adder_if #(.CNT_W(2)) bus2 ();

    half_adder #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    half_adder #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one accepted input; its result is expected one edge later.
    task automatic send(input logic a, input logic b, input logic clr_i);
        exp_t e;
        @(posedge clk);
        #1;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        bus.clr = clr_i;
        if (clr_i) begin
            m_op = 0;
            m_carry = 0;
        end else begin
            if (m_op != 255) m_op++;
            if ((a & b) && m_carry != 255) m_carry++;
        end
        e.s_q = a ^ b;
        e.c_q = a & b;
        e.op = 8'(m_op);
        e.carry = 8'(m_carry);
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
    endtask

    // Reset discards any queued expectation along with the in-flight result.
    task automatic assert_reset();
        rst_n = 1'b0;
        q.delete();
        m_op = 0;
        m_carry = 0;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
    endtask

    // Monitor: every out_valid cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("s_q", {31'd0, bus.s_q}, {31'd0, e.s_q});
                chk("c_q", {31'd0, bus.c_q}, {31'd0, e.c_q});
                chk("op_cnt", {24'd0, bus.op_cnt}, {24'd0, e.op});
                chk("carry_cnt", {24'd0, bus.carry_cnt}, {24'd0, e.carry});
            end
        end
    end

    logic [3:0] exp_s_tbl;
    logic [3:0] exp_c_tbl;

    initial begin
        exp_s_tbl = 4'b0110;  // index = {a,b}: 00->0, 01->1, 10->1, 11->0
        exp_c_tbl = 4'b1000;  // only 11 carries
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        bus2.a = 1'b0;
        bus2.b = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.clr = 1'b0;

        // Combinational path with no clock and rst_n left undriven.
        for (int i = 0; i < 4; i++) begin
            bus.a = i[1];
            bus.b = i[0];
            #1;
            chk("comb_s", {31'd0, bus.s}, {31'd0, exp_s_tbl[i]});
            chk("comb_c", {31'd0, bus.c}, {31'd0, exp_c_tbl[i]});
            #1;
        end

        assert_reset();
        bus.a = 1'b0;
        bus.b = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_q", {31'd0, bus.s_q}, 32'd0);
        chk("rst_c_q", {31'd0, bus.c_q}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_op_cnt", {24'd0, bus.op_cnt}, 32'd0);
        chk("rst_carry_cnt", {24'd0, bus.carry_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single 11 accept, then out_valid must drop with counters at 1.
        send(1'b1, 1'b1, 1'b0);
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("single_ov_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("single_op_cnt", {24'd0, bus.op_cnt}, 32'd1);
        chk("single_carry_cnt", {24'd0, bus.carry_cnt}, 32'd1);

        // Stream all four combos from a fresh reset, then hold.
        assert_reset();
        #2;
        rst_n = 1'b1;
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        idle();
        repeat (3) idle();
        @(negedge clk);
        chk("stream_op_cnt", {24'd0, bus.op_cnt}, 32'd4);
        chk("stream_carry_cnt", {24'd0, bus.carry_cnt}, 32'd1);
        chk("hold_s_q", {31'd0, bus.s_q}, 32'd0);
        chk("hold_c_q", {31'd0, bus.c_q}, 32'd1);

        // clr coincident with an accepted 11, then a following accept counts from zero.
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        idle();

        // 8-bit saturation: 260 carries pin both counters at 255.
        for (int i = 0; i < 260; i++) send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("sat_op_cnt", {24'd0, bus.op_cnt}, 32'd255);
        chk("sat_carry_cnt", {24'd0, bus.carry_cnt}, 32'd255);

        // CNT_W=2 instance: six accepted 11 inputs stop both counters at 3.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus2.a = 1'b1;
            bus2.b = 1'b1;
            bus2.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("w2_op_cnt", {30'd0, bus2.op_cnt}, 32'd3);
        chk("w2_carry_cnt", {30'd0, bus2.carry_cnt}, 32'd3);

        // Reset pulsed between edges after activity: registered outputs clear at once, s/c stay live.
        send(1'b1, 1'b1, 1'b0);
        idle();
        @(posedge clk);
        #3;
        assert_reset();
        #1;
        chk("async_s_q", {31'd0, bus.s_q}, 32'd0);
        chk("async_c_q", {31'd0, bus.c_q}, 32'd0);
        chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_op_cnt", {24'd0, bus.op_cnt}, 32'd0);
        chk("async_carry_cnt", {24'd0, bus.carry_cnt}, 32'd0);
        chk("async_s_live", {31'd0, bus.s}, 32'd0);
        chk("async_c_live", {31'd0, bus.c}, 32'd1);

        // Inputs ignored while held in reset.
        bus.a = 1'b1;
        bus.b = 1'b0;
        bus.in_valid = 1'b1;
        bus.clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("inrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("inrst_op_cnt", {24'd0, bus.op_cnt}, 32'd0);
        chk("inrst_s_q", {31'd0, bus.s_q}, 32'd0);
        chk("inrst_s_live", {31'd0, bus.s}, 32'd1);
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // In-flight accept killed by reset before its edge; next accept counts from one.
        send(1'b1, 1'b1, 1'b0);
        #3;
        assert_reset();
        #2;
        rst_n = 1'b1;
        send(1'b0, 1'b1, 1'b0);
        idle();
        repeat (2) idle();
        @(negedge clk);
        chk("flight_op_cnt", {24'd0, bus.op_cnt}, 32'd1);
        chk("flight_carry_cnt", {24'd0, bus.carry_cnt}, 32'd0);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
